// File: rtl/sp_sync_ram_be_if.sv
// Request/response bundle for sp_sync_ram_be.
// The master side issues valid/ready requests (read or byte-masked write).
// The slave side returns read responses with no backpressure and reports
// whether the post-reset clear sequence is still running.
//   req_valid/req_ready : request handshake
//   req_we/req_addr     : 1 = write, 0 = read; word address
//   req_be/req_wdata    : per-byte write enables and write data
//   rsp_valid           : one-cycle pulse per accepted read
//   rsp_rdata/rsp_err   : read data and out-of-range flag
//   busy                : clear sequence in progress
interface sp_sync_ram_be_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH/8-1:0] req_be;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;
    logic                    busy;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/sp_sync_ram_be.sv
// Single-port synchronous RAM with byte-enable writes, read latency of 1 or
// 2 cycles, out-of-range flagging and an optional zero-fill after reset.
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous, active-high reset
//   bus : sp_sync_ram_be_if slave port (request, response, busy)
// The memory array itself is never reset; only control state and the read
// pipeline are. With CLEAR_ON_RESET=1 the INIT state walks every word and
// writes zero, one word per cycle, before requests are accepted.
module sp_sync_ram_be #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 16,
    parameter int RD_LATENCY     = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic               clk,
    input  logic               rst,
    sp_sync_ram_be_if.slave    bus
);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
    // One extra bit so DEPTH == 2**ADDR_WIDTH compares correctly.
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_L  = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state_r, state_s;
    logic [ADDR_WIDTH-1:0]   clr_cnt_r, clr_cnt_s;
    logic                    clr_we_s;
    logic                    ready_r;
    logic                    busy_r;

    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    logic                    accept_s;
    logic                    in_range_s;
    logic                    wr_s;
    logic                    rd_s;
    logic [DATA_WIDTH-1:0]   rd_data_s;

    logic                    s1_valid_r;
    logic [DATA_WIDTH-1:0]   s1_data_r;
    logic                    s1_err_r;

    // ready is a registered decode of state, so it never depends on req_valid
    assign accept_s   = bus.req_valid & ready_r;
    assign in_range_s = ({1'b0, bus.req_addr} < DEPTH_L);
    assign wr_s       = accept_s & bus.req_we & in_range_s;
    assign rd_s       = accept_s & ~bus.req_we;

    // Next-state logic: clear counter walks 0..DEPTH-1 in INIT
    always_comb begin
        state_s   = state_r;
        clr_cnt_s = clr_cnt_r;
        clr_we_s  = 1'b0;
        case (state_r)
            ST_INIT: begin
                clr_we_s = 1'b1;
                if (clr_cnt_r == LAST_L) begin
                    state_s   = ST_READY;
                    clr_cnt_s = {ADDR_WIDTH{1'b0}};
                end else begin
                    clr_cnt_s = clr_cnt_r + ADDR_WIDTH'(1);
                end
            end
            ST_READY: begin
                state_s = ST_READY;
            end
            default: begin
                state_s   = RST_STATE;
                clr_cnt_s = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // State register plus registered ready/busy decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= RST_STATE;
            clr_cnt_r <= {ADDR_WIDTH{1'b0}};
            ready_r   <= (RST_STATE == ST_READY);
            busy_r    <= (RST_STATE == ST_INIT);
        end else begin
            state_r   <= state_s;
            clr_cnt_r <= clr_cnt_s;
            ready_r   <= (state_s == ST_READY);
            busy_r    <= (state_s == ST_INIT);
        end
    end

    // Storage array: zero-fill during INIT, byte-masked writes otherwise
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_r[clr_cnt_r] <= {DATA_WIDTH{1'b0}};
        end else if (wr_s) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.req_be[i]) begin
                    mem_r[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read data mux: out-of-range reads return zero
    always_comb begin
        rd_data_s = {DATA_WIDTH{1'b0}};
        if (in_range_s) begin
            rd_data_s = mem_r[bus.req_addr];
        end else begin
            rd_data_s = {DATA_WIDTH{1'b0}};
        end
    end

    // First read stage: data/err only load on a read so they hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {DATA_WIDTH{1'b0}};
            s1_err_r   <= 1'b0;
        end else begin
            s1_valid_r <= rd_s;
            if (rd_s) begin
                s1_data_r <= rd_data_s;
                s1_err_r  <= ~in_range_s;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  s2_valid_r;
            logic [DATA_WIDTH-1:0] s2_data_r;
            logic                  s2_err_r;

            // Output register stage, loads only on a stage-1 response
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_valid_r <= 1'b0;
                    s2_data_r  <= {DATA_WIDTH{1'b0}};
                    s2_err_r   <= 1'b0;
                end else begin
                    s2_valid_r <= s1_valid_r;
                    if (s1_valid_r) begin
                        s2_data_r <= s1_data_r;
                        s2_err_r  <= s1_err_r;
                    end
                end
            end

            assign bus.rsp_valid = s2_valid_r;
            assign bus.rsp_rdata = s2_data_r;
            assign bus.rsp_err   = s2_err_r;
        end else begin : g_lat1
            assign bus.rsp_valid = s1_valid_r;
            assign bus.rsp_rdata = s1_data_r;
            assign bus.rsp_err   = s1_err_r;
        end
    endgenerate

    assign bus.req_ready = ready_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_sp_sync_ram_be.sv
// Directed bench for sp_sync_ram_be with two instances sharing clk/rst:
//   a: DEPTH=16, RD_LATENCY=1, CLEAR_ON_RESET=1
//   b: DEPTH=12, RD_LATENCY=2, CLEAR_ON_RESET=1
// Reads push an expected {data, err, cycle} into a per-instance queue; the
// response monitor pops and compares on every rsp_valid pulse.
module tb_sp_sync_ram_be;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sp_sync_ram_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) ia ();
    sp_sync_ram_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) ib ();

    sp_sync_ram_be #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(16),
        .RD_LATENCY(1), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(ia)
    );

    sp_sync_ram_be #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(12),
        .RD_LATENCY(2), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(ib)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        q [2][$];
    logic [31:0] model [2][16];
    logic [31:0] last_d [2];
    logic        last_e [2];
    int          depth [2] = '{16, 12};
    int          rdl [2]   = '{1, 2};
    int          cyc;
    int          n_assert;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic mon(input int k, input logic v, input logic [31:0] d, input logic e);
        exp_t x;
        if (v === 1'b1) begin
            chk($sformatf("rsp%0d_expected", k), 32'(q[k].size() > 0), 32'd1);
            if (q[k].size() > 0) begin
                x = q[k].pop_front();
                chk($sformatf("rsp%0d_data", k), d, x.data);
                chk($sformatf("rsp%0d_err", k), 32'(e), 32'(x.err));
                chk($sformatf("rsp%0d_cycle", k), 32'(cyc), 32'(x.cyc));
            end
            last_d[k] = d;
            last_e[k] = e;
        end else begin
            chk($sformatf("rsp%0d_valid_low", k), 32'(v), 32'd0);
            chk($sformatf("rsp%0d_hold_data", k), d, last_d[k]);
            chk($sformatf("rsp%0d_hold_err", k), 32'(e), 32'(last_e[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        mon(0, ia.rsp_valid, ia.rsp_rdata, ia.rsp_err);
        mon(1, ib.rsp_valid, ib.rsp_rdata, ib.rsp_err);
    endtask

    task automatic req(input int k, input logic we, input logic [3:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
        exp_t e;
        chk($sformatf("ready%0d", k), 32'(k == 0 ? ia.req_ready : ib.req_ready), 32'd1);
        if (k == 0) begin
            ia.req_valid = 1'b1; ia.req_we = we; ia.req_addr = addr;
            ia.req_be = be; ia.req_wdata = wd;
        end else begin
            ib.req_valid = 1'b1; ib.req_we = we; ib.req_addr = addr;
            ib.req_be = be; ib.req_wdata = wd;
        end
        if (we) begin
            if (int'(addr) < depth[k]) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) model[k][addr][8*i +: 8] = wd[8*i +: 8];
                end
            end
        end else begin
            e.err  = !(int'(addr) < depth[k]);
            e.data = e.err ? 32'h0 : model[k][addr];
            e.cyc  = cyc + rdl[k];
            q[k].push_back(e);
        end
        tick();
        if (k == 0) ia.req_valid = 1'b0;
        else        ib.req_valid = 1'b0;
    endtask

    // Pulse rst for one cycle; in-flight reads are discarded, memory re-zeroed
    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            q[k].delete();
            last_d[k] = 32'h0;
            last_e[k] = 1'b0;
            for (int a = 0; a < 16; a++) model[k][a] = 32'h0;
        end
        tick();
        chk("rst_ready_a", 32'(ia.req_ready), 32'd0);
        chk("rst_busy_a", 32'(ia.busy), 32'd1);
        chk("rst_ready_b", 32'(ib.req_ready), 32'd0);
        chk("rst_busy_b", 32'(ib.busy), 32'd1);
        rst = 1'b0;
        cyc = 0;
    endtask

    // Cycle k after release: busy until cycle DEPTH, then ready
    task automatic init_check(input int ncyc);
        for (int k = 0; k <= ncyc; k++) begin
            chk($sformatf("busy_a_c%0d", k), 32'(ia.busy), 32'(k < 16));
            chk($sformatf("ready_a_c%0d", k), 32'(ia.req_ready), 32'(k >= 16));
            chk($sformatf("busy_b_c%0d", k), 32'(ib.busy), 32'(k < 12));
            chk($sformatf("ready_b_c%0d", k), 32'(ib.req_ready), 32'(k >= 12));
            if (k < ncyc) tick();
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        ia.req_valid = 1'b0; ia.req_we = 1'b0; ia.req_addr = 4'h0;
        ia.req_be = 4'h0; ia.req_wdata = 32'h0;
        ib.req_valid = 1'b0; ib.req_we = 1'b0; ib.req_addr = 4'h0;
        ib.req_be = 4'h0; ib.req_wdata = 32'h0;

        @(negedge clk);
        do_reset();
        init_check(5);
        // reset in the middle of INIT: clear restarts from word 0
        do_reset();
        init_check(17);

        // every word reads back zero after the clear
        for (int i = 0; i < 16; i++) req(0, 1'b0, 4'(i), 4'h0, 32'h0);
        for (int i = 0; i < 12; i++) req(1, 1'b0, 4'(i), 4'h0, 32'h0);
        drain(3);

        // byte enables: full write, partial write, empty mask
        req(0, 1'b1, 4'd3, 4'hF, 32'hAABBCCDD);
        req(0, 1'b1, 4'd3, 4'h5, 32'h11223344);
        req(0, 1'b1, 4'd3, 4'h0, 32'hDEADBEEF);
        req(0, 1'b0, 4'd3, 4'h0, 32'h0);
        req(0, 1'b1, 4'd15, 4'hA, 32'h87654321);
        req(0, 1'b0, 4'd15, 4'h0, 32'h0);
        // read on the edge right after a write to the same word
        req(0, 1'b1, 4'd5, 4'hF, 32'h5A5A5A5A);
        req(0, 1'b0, 4'd5, 4'h0, 32'h0);
        drain(2);

        // latency 2: back-to-back reads come back on consecutive cycles
        req(1, 1'b1, 4'd1, 4'hF, 32'h1);
        req(1, 1'b1, 4'd2, 4'hF, 32'h2);
        req(1, 1'b1, 4'd3, 4'hF, 32'h3);
        req(1, 1'b0, 4'd1, 4'h0, 32'h0);
        req(1, 1'b0, 4'd2, 4'h0, 32'h0);
        req(1, 1'b0, 4'd3, 4'h0, 32'h0);
        drain(3);

        // out-of-range on DEPTH=12: writes dropped, reads flagged
        req(1, 1'b1, 4'd13, 4'hF, 32'hFFFFFFFF);
        req(1, 1'b1, 4'd12, 4'hF, 32'hFFFFFFFF);
        req(1, 1'b0, 4'd13, 4'h0, 32'h0);
        req(1, 1'b0, 4'd11, 4'h0, 32'h0);
        req(1, 1'b0, 4'd12, 4'h0, 32'h0);
        for (int i = 0; i < 12; i++) req(1, 1'b0, 4'(i), 4'h0, 32'h0);
        drain(3);

        // reset with a latency-2 read in flight: its response is discarded
        req(1, 1'b0, 4'd2, 4'h0, 32'h0);
        do_reset();
        init_check(17);
        req(1, 1'b0, 4'd2, 4'h0, 32'h0);
        req(0, 1'b0, 4'd3, 4'h0, 32'h0);
        drain(3);

        chk("queue_a_empty", 32'(q[0].size()), 32'd0);
        chk("queue_b_empty", 32'(q[1].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
